// File: rtl/i2c_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_frame_timer
// Description : Tracks I2C byte/ACK framing from pre-detected SCL edge and
//               START/STOP pulses. Counts data bits, steps through the ACK
//               slot and emits single-cycle registered timing pulses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_BITS : data bits per frame before the ACK slot (2..16)
//   BCNT_W    : width of byte_count
// Ports
//   clk                 in  : clock, rising edge active
//   rst                 in  : synchronous active-high reset
//   rising_edge_found   in  : SCL rising edge pulse
//   falling_edge_found  in  : SCL falling edge pulse
//   start_found         in  : START / repeated START pulse
//   stop_found          in  : STOP pulse
//   byte_received       out : last data bit sampled
//   ack_prep            out : drive ACK now
//   check_ack           out : sample ACK now
//   ack_done            out : ACK slot finished
//   frame_error         out : frame aborted by START/STOP mid-byte/mid-ACK
//   bit_index           out : data bits sampled in current byte
//   byte_count          out : bytes completed since last START
//   busy                out : high whenever not idle
// Configuration
//   I2C_FRAME_TIMER_BYTE_COUNT_EN : when defined, byte_count is a live
//   saturating counter; otherwise it is tied to zero.
// ============================================================================
module i2c_frame_timer #(
    parameter int DATA_BITS = 8,
    parameter int BCNT_W    = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rising_edge_found,
    input  logic                             falling_edge_found,
    input  logic                             start_found,
    input  logic                             stop_found,
    output logic                             byte_received,
    output logic                             ack_prep,
    output logic                             check_ack,
    output logic                             ack_done,
    output logic                             frame_error,
    output logic [$clog2(DATA_BITS+1)-1:0]   bit_index,
    output logic [BCNT_W-1:0]                byte_count,
    output logic                             busy
);

    localparam int BI_W = $clog2(DATA_BITS + 1);

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_data       = 3'd1;
    localparam logic [2:0] c_st_ack_wait   = 3'd2;
    localparam logic [2:0] c_st_ack_sample = 3'd3;
    localparam logic [2:0] c_st_ack_end    = 3'd4;

    // Bit index value just before the final data bit is sampled.
    localparam logic [BI_W-1:0] c_last_m1 = BI_W'(DATA_BITS - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [BI_W-1:0] r_bit_index;
    logic [BI_W-1:0] w_bit_index_d;
    logic            w_rise;
    logic            w_fall;
    logic            w_abort;
    logic            w_byte_received_d;
    logic            w_ack_prep_d;
    logic            w_check_ack_d;
    logic            w_ack_done_d;
    logic            w_frame_error_d;

    // A simultaneous rising edge wins; the falling edge is dropped.
    assign w_rise = rising_edge_found;
    assign w_fall = falling_edge_found & ~rising_edge_found;

    // START/STOP counts as an abort only once a byte is under way.
    assign w_abort = ((r_state == c_st_data) && (r_bit_index != '0)) ||
                     (r_state == c_st_ack_wait) ||
                     (r_state == c_st_ack_sample) ||
                     (r_state == c_st_ack_end);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (start_found) begin
            w_next_state = c_st_data;
        end else if (stop_found) begin
            w_next_state = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: ;
                c_st_data:
                    if (w_rise && (r_bit_index == c_last_m1)) w_next_state = c_st_ack_wait;
                c_st_ack_wait:
                    if (w_fall) w_next_state = c_st_ack_sample;
                c_st_ack_sample:
                    if (w_rise) w_next_state = c_st_ack_end;
                c_st_ack_end:
                    if (w_fall) w_next_state = c_st_data;
                default:
                    w_next_state = c_st_idle;
            endcase
        end
    end

    // Output logic: values presented on the cycle after the qualifying input
    always_comb begin
        w_byte_received_d = 1'b0;
        w_ack_prep_d      = 1'b0;
        w_check_ack_d     = 1'b0;
        w_ack_done_d      = 1'b0;
        w_frame_error_d   = 1'b0;
        w_bit_index_d     = r_bit_index;
        if (start_found || stop_found) begin
            w_frame_error_d = w_abort;
            w_bit_index_d   = '0;
        end else begin
            case (r_state)
                c_st_data:
                    if (w_rise) begin
                        w_bit_index_d     = r_bit_index + BI_W'(1);
                        w_byte_received_d = (r_bit_index == c_last_m1);
                    end
                c_st_ack_wait:
                    w_ack_prep_d = w_fall;
                c_st_ack_sample:
                    w_check_ack_d = w_rise;
                c_st_ack_end:
                    if (w_fall) begin
                        w_ack_done_d  = 1'b1;
                        w_bit_index_d = '0;
                    end
                default: ;
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_received <= 1'b0;
            ack_prep      <= 1'b0;
            check_ack     <= 1'b0;
            ack_done      <= 1'b0;
            frame_error   <= 1'b0;
            r_bit_index   <= '0;
            busy          <= 1'b0;
        end else begin
            byte_received <= w_byte_received_d;
            ack_prep      <= w_ack_prep_d;
            check_ack     <= w_check_ack_d;
            ack_done      <= w_ack_done_d;
            frame_error   <= w_frame_error_d;
            r_bit_index   <= w_bit_index_d;
            busy          <= (w_next_state != c_st_idle);
        end
    end

    assign bit_index = r_bit_index;

`ifdef I2C_FRAME_TIMER_BYTE_COUNT_EN
    logic [BCNT_W-1:0] r_byte_count;

    // Cleared by START, held by STOP, saturating increment per finished ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_count <= '0;
        end else if (start_found) begin
            r_byte_count <= '0;
        end else if (w_ack_done_d && (r_byte_count != '1)) begin
            r_byte_count <= r_byte_count + BCNT_W'(1);
        end
    end

    assign byte_count = r_byte_count;
`else
    assign byte_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_frame_timer
// Description : Scoreboard bench for i2c_frame_timer. Two instances (8 data
//               bits / 8-bit count and 9 data bits / 2-bit count) share the
//               same stimulus; a behavioural frame model predicts every
//               cycle's outputs and a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_frame_timer;

    localparam int DB_A = 8;
    localparam int BW_A = 8;
    localparam int DB_B = 9;
    localparam int BW_B = 2;
`ifdef I2C_FRAME_TIMER_BYTE_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    typedef struct {
        bit frame;   // between START and STOP
        int bits;    // data bits seen in the current byte
        int ack;     // 0: data phase, 1..3: waiting for the next ACK-slot edge
        int cnt;     // completed bytes
    } model_t;

    typedef struct {
        bit brx, prep, chk, done, ferr, busy;
        int bidx;
        int bcnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst, rising, falling, start, stop;

    logic            a_brx, a_prep, a_chk, a_done, a_ferr, a_busy;
    logic [3:0]      a_bidx;
    logic [BW_A-1:0] a_bcnt;
    logic            b_brx, b_prep, b_chk, b_done, b_ferr, b_busy;
    logic [3:0]      b_bidx;
    logic [BW_B-1:0] b_bcnt;

    always #5 clk = ~clk;

    i2c_frame_timer #(.DATA_BITS(DB_A), .BCNT_W(BW_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .rising_edge_found(rising), .falling_edge_found(falling),
        .start_found(start), .stop_found(stop),
        .byte_received(a_brx), .ack_prep(a_prep), .check_ack(a_chk),
        .ack_done(a_done), .frame_error(a_ferr),
        .bit_index(a_bidx), .byte_count(a_bcnt), .busy(a_busy)
    );

    i2c_frame_timer #(.DATA_BITS(DB_B), .BCNT_W(BW_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .rising_edge_found(rising), .falling_edge_found(falling),
        .start_found(start), .stop_found(stop),
        .byte_received(b_brx), .ack_prep(b_prep), .check_ack(b_chk),
        .ack_done(b_done), .frame_error(b_ferr),
        .bit_index(b_bidx), .byte_count(b_bcnt), .busy(b_busy)
    );

    obs_t   q_a[$];
    obs_t   q_b[$];
    model_t m_a, m_b;
    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc_n    = 0;

    // Frame model: what the outputs must show after one clock with these inputs.
    task automatic model_step(input model_t mi, input int db, input int cmax,
                              input bit x, input bit r, input bit f,
                              input bit s, input bit p,
                              output model_t mo, output obs_t e);
        bit mid_frame;
        bit fo;
        mo = mi;
        e  = '{default: 0};
        fo = f && !r;
        mid_frame = mi.frame && (mi.bits != 0 || mi.ack != 0);
        if (x) begin
            mo = '{frame: 0, bits: 0, ack: 0, cnt: 0};
        end else if (s) begin
            e.ferr = mid_frame;
            mo = '{frame: 1, bits: 0, ack: 0, cnt: 0};
        end else if (p) begin
            e.ferr   = mid_frame;
            mo.frame = 0;
            mo.bits  = 0;
            mo.ack   = 0;
        end else if (mi.frame) begin
            if (mi.ack == 0 && r) begin
                mo.bits = mi.bits + 1;
                if (mo.bits == db) begin
                    e.brx  = 1;
                    mo.ack = 1;
                end
            end else if (mi.ack == 1 && fo) begin
                e.prep = 1;
                mo.ack = 2;
            end else if (mi.ack == 2 && r) begin
                e.chk  = 1;
                mo.ack = 3;
            end else if (mi.ack == 3 && fo) begin
                e.done  = 1;
                mo.ack  = 0;
                mo.bits = 0;
                mo.cnt  = (mi.cnt < cmax) ? mi.cnt + 1 : mi.cnt;
            end
        end
        e.busy = mo.frame;
        e.bidx = mo.bits;
        e.bcnt = COUNT_EN ? mo.cnt : 0;
    endtask

    task automatic compare(input string nm, input obs_t ex, input obs_t ac);
        bit ok;
        ok = (ex.brx == ac.brx) && (ex.prep == ac.prep) && (ex.chk == ac.chk) &&
             (ex.done == ac.done) && (ex.ferr == ac.ferr) && (ex.busy == ac.busy) &&
             (ex.bidx == ac.bidx) && (ex.bcnt == ac.bcnt);
        n_checks++;
        if (ok) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: actual brx=%0d prep=%0d chk=%0d done=%0d ferr=%0d busy=%0d bidx=%0d bcnt=%0d required brx=%0d prep=%0d chk=%0d done=%0d ferr=%0d busy=%0d bidx=%0d bcnt=%0d",
                     nm, cyc_n, ac.brx, ac.prep, ac.chk, ac.done, ac.ferr, ac.busy, ac.bidx, ac.bcnt,
                     ex.brx, ex.prep, ex.chk, ex.done, ex.ferr, ex.busy, ex.bidx, ex.bcnt);
        end
    endtask

    // Drive one cycle of inputs and queue the predicted response of both DUTs.
    task automatic step(input bit x, input bit r, input bit f, input bit s, input bit p);
        obs_t e;
        @(negedge clk);
        rst = x; rising = r; falling = f; start = s; stop = p;
        model_step(m_a, DB_A, (1 << BW_A) - 1, x, r, f, s, p, m_a, e);
        q_a.push_back(e);
        model_step(m_b, DB_B, (1 << BW_B) - 1, x, r, f, s, p, m_b, e);
        q_b.push_back(e);
    endtask

    task automatic full_byte(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 1, 0, 0);
        end
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    // Monitor: one response per clock, sampled just after the active edge.
    initial begin
        obs_t ea, eb, aa, ab;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            aa = '{brx: a_brx, prep: a_prep, chk: a_chk, done: a_done, ferr: a_ferr,
                   busy: a_busy, bidx: int'(a_bidx), bcnt: int'(a_bcnt)};
            ab = '{brx: b_brx, prep: b_prep, chk: b_chk, done: b_done, ferr: b_ferr,
                   busy: b_busy, bidx: int'(b_bidx), bcnt: int'(b_bcnt)};
            if (q_a.size() > 0) begin
                ea = q_a.pop_front();
                compare("dut8", ea, aa);
            end
            if (q_b.size() > 0) begin
                eb = q_b.pop_front();
                compare("dut9", eb, ab);
            end
        end
    end

    initial begin
        int v;
        bit x, r, f, s, p;
        m_a = '{frame: 0, bits: 0, ack: 0, cnt: 0};
        m_b = m_a;
        rst = 1'b1; rising = 1'b0; falling = 1'b0; start = 1'b0; stop = 1'b0;

        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0);

        // Three complete bytes after one START, then STOP.
        step(0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) full_byte(DB_A);
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0);

        // Abort after four data bits.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Repeated START while waiting to sample ACK.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < DB_A; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Coincident edges count once; START at bit 0 and STOP in idle are clean.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < DB_B; i++) step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Reset mid-byte.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        // Enough 9-bit bytes to saturate the 2-bit counter.
        step(0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) full_byte(DB_B);
        step(0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            v = int'($urandom_range(0, 999));
            x = (v < 3);
            s = (v >= 3) && (v < 8);
            p = (v >= 8) && (v < 13);
            r = ($urandom_range(0, 99) < 35);
            f = ($urandom_range(0, 99) < 35);
            step(x, r, f, s, p);
        end
        step(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        n_checks++;
        if (q_a.size() == 0 && q_b.size() == 0) n_pass++;
        else $display("FAIL drain: actual pending=%0d/%0d required 0/0", q_a.size(), q_b.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
